// File: rtl/noc_pkg.sv
// Shared types and defaults for the NoC local-port scheduler.
package noc_pkg;

  localparam int FLIT_W      = 16;
  localparam int N_REQ_DEF   = 4;
  localparam int CREDITS_DEF = 4;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/noc_local_sched_if.sv
// Source-side and router-side signals of the local-port scheduler, bundled as one port.
interface noc_local_sched_if
  import noc_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) ();

  flit_t [N_REQ-1:0] src_flit_i;
  logic  [N_REQ-1:0] src_valid_i;
  logic  [N_REQ-1:0] src_last_i;
  logic  [N_REQ-1:0] src_rdy_o;
  flit_t             local_o;
  logic              valid_o;
  logic              incr_i;
  logic              cred_err_o;

  modport slave (
    input  src_flit_i,
    input  src_valid_i,
    input  src_last_i,
    input  incr_i,
    output src_rdy_o,
    output local_o,
    output valid_o,
    output cred_err_o
  );

  modport master (
    output src_flit_i,
    output src_valid_i,
    output src_last_i,
    output incr_i,
    input  src_rdy_o,
    input  local_o,
    input  valid_o,
    input  cred_err_o
  );

endinterface

// File: rtl/noc_local_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr_i, wrapping to 0.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    logic          found;
    int            sum;
    logic [PW-1:0] idx;
    gnt_o = '0;
    found = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      sum = int'(ptr_i) + off;
      if (sum >= N) sum = sum - N;
      idx = PW'(sum);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_local_sched.sv
// Packet-atomic, credit-gated scheduler feeding N_REQ sources into one router local input port.
module noc_local_sched
  import noc_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int CREDITS = CREDITS_DEF
) (
  input logic              clk,
  input logic              rst,
  noc_local_sched_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

  sched_state_t  state_q;
  logic [PW-1:0] gnt_q;
  logic [PW-1:0] ptr_q;
  logic [CW-1:0] credits_q;
  logic [CW-1:0] credits_d;
  flit_t         local_q;
  logic          valid_q;
  logic          cred_err_q;

  logic [N_REQ-1:0] arb_gnt;
  logic [N_REQ-1:0] rdy;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    xfer_idx;
  logic [PW-1:0]    next_ptr;
  logic             has_cred;
  logic             xfer;
  logic             xfer_last;
  logic             overflow;
  flit_t            xfer_flit;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req_i (bus.src_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) win_idx = PW'(i);
    end
  end

  assign has_cred = (credits_q != '0);

  // Ready is combinational on src_valid_i in IDLE; in LOCK it only depends on credits.
  always_comb begin
    rdy = '0;
    if (!rst && has_cred) begin
      if (state_q == IDLE) rdy = arb_gnt;
      else                 rdy[gnt_q] = 1'b1;
    end
  end

  assign xfer      = |(rdy & bus.src_valid_i);
  assign xfer_idx  = (state_q == IDLE) ? win_idx : gnt_q;
  assign xfer_last = bus.src_last_i[xfer_idx];
  assign xfer_flit = bus.src_flit_i[xfer_idx];
  assign next_ptr  = (xfer_idx == PTR_LAST) ? '0 : xfer_idx + PW'(1);

  // A simultaneous transfer and credit return cancel out.
  always_comb begin
    credits_d = credits_q;
    overflow  = 1'b0;
    case ({xfer, bus.incr_i})
      2'b10: credits_d = credits_q - CW'(1);
      2'b01: begin
        if (credits_q == CRED_MAX) overflow  = 1'b1;
        else                       credits_d = credits_q + CW'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ptr_q      <= '0;
      credits_q  <= CRED_MAX;
      local_q    <= '0;
      valid_q    <= 1'b0;
      cred_err_q <= 1'b0;
    end else begin
      valid_q   <= xfer;
      credits_q <= credits_d;
      if (xfer)     local_q    <= xfer_flit;
      if (overflow) cred_err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (xfer_last) begin
              ptr_q <= next_ptr;
            end else begin
              state_q <= LOCK;
              gnt_q   <= xfer_idx;
            end
          end
        end
        LOCK: begin
          if (xfer && xfer_last) begin
            state_q <= IDLE;
            ptr_q   <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.src_rdy_o  = rdy;
  assign bus.local_o    = local_q;
  assign bus.valid_o    = valid_q;
  assign bus.cred_err_o = cred_err_q;

  a_rdy_onehot0: assert property (@(posedge clk) $onehot0(rdy));
  a_cred_range:  assert property (@(posedge clk) disable iff (rst) credits_q <= CRED_MAX);

endmodule
